imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses starting from 0, and the stream is checked against a trailing XOR checksum. The core is held in reset while loading and released only after a successful load.

## Interface
Parameters:
- ADDR_W, 5, instruction-memory word-address width; capacity is 2^ADDR_W words.
- LITTLE_END, 0, byte order. 0 means the first byte of a word goes to [31:24]. 1 means the first byte goes to [7:0].

Ports:
- Clocking is fixed: one clock, `i_clk`. Reset is `i_rst`, asynchronous and active-high.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE and ERR.
- i_byte  in  8  stream byte.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader accepts a byte; a transfer occurs when valid and ready are both high on a clock edge.
- o_we  out  1  instruction-memory write strobe, one cycle per word.
- o_waddr  out  ADDR_W  word address for o_we.
- o_wdata  out  32  word to write.
- o_cpu_rst_n  out  1  reset to the core, active-low; high only in DONE.
- o_busy  out  1  load in progress (COUNT, DATA or CHECK).
- o_done  out  1  last load succeeded.
- o_err  out  1  last load failed its checksum.

## Operation
- Stream format: one count byte C, then 4*(C[ADDR_W-1:0]+1) data bytes, then one checksum byte.
  - The checksum is the XOR of all data bytes; the count byte is not included.
  - Bits of C above ADDR_W-1 are ignored.
- States:
  - IDLE: i_start goes to COUNT.
  - COUNT: accept C. Latch the word total N = C[ADDR_W-1:0]+1 as an ADDR_W+1-bit value. Clear the word index, byte index and XOR accumulator, then go to DATA.
  - DATA: on each byte transfer, shift the byte into the assembly register per LITTLE_END, XOR it into the accumulator, and increment the 2-bit byte index.
    - On the 4th byte: register the word into o_wdata, set o_waddr to the word index, pulse o_we, and increment the word index.
    - If the word index reaches N, go to CHECK.
  - CHECK: accept the checksum byte.
    - If it equals the accumulator, go to DONE.
    - Otherwise go to ERR.
  - DONE: o_done=1, o_cpu_rst_n=1. i_start goes to COUNT.
  - ERR: o_err=1, o_cpu_rst_n=0. i_start goes to COUNT.
- o_byte_ready = 1 exactly in COUNT, DATA and CHECK. Bytes presented with valid low are ignored.
- i_start is ignored in COUNT, DATA and CHECK.
- Restarting from DONE or ERR:
  - o_done and o_err clear on entry to COUNT.
  - o_cpu_rst_n falls on entry to COUNT.
- Memory contents are never cleared. Words written before a reset or a checksum failure remain in memory.
- Write overlap: o_we of a completed word coincides with the loader being ready for the next byte. The assembly register and o_wdata are separate registers, so this overlap is allowed.

## Timing
- Reset (asynchronous, immediate) puts the FSM in IDLE with all outputs low: o_byte_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_busy, o_done and o_err are all 0.
- Reset mid-load abandons the load. The next i_start reloads from address 0.
- i_start high in IDLE at edge k: the loader is in COUNT with o_byte_ready=1 and o_busy=1 after edge k.
- 4th byte of a word transferred at edge k: o_we=1 with valid o_waddr and o_wdata for exactly the cycle after edge k.
- Checksum byte transferred at edge k: after edge k, o_done or o_err is 1, o_busy=0, and o_byte_ready=0.
- Throughput is one byte per cycle and there are no bubbles. The minimum load time is 4N+3 cycles from i_start.
- Word index wrap: a full load (N = 2^ADDR_W) ends with o_waddr = 2^ADDR_W-1. The ADDR_W+1-bit index comparison prevents wrap from aliasing the end condition.

## Test plan
- Two-word load, ADDR_W=5, LITTLE_END=0:
  - Stimulus: start, then bytes 01, 20 08 00 05, 8C 09 00 04, checksum AC.
  - Response: o_we writes 20080005 at address 0 and 8C090004 at address 1; then o_done=1, o_cpu_rst_n=1.
- Same stream with checksum AD: both writes occur, then o_err=1, o_done=0, o_cpu_rst_n stays 0.
- Same stream with i_byte_valid toggled randomly, and garbage on i_byte while valid is low: identical writes and o_done=1.
- Capacity: count 1F gives 32 writes to addresses 0..31 and DONE. Count FF with ADDR_W=5 behaves identically.
- Reset:
  - Assert i_rst after the 6th data byte: all outputs 0 immediately, FSM in IDLE.
  - A subsequent load of the two-word stream writes address 0 first and reaches DONE.
- Start handling:
  - i_start pulsed during DATA has no effect.
  - i_start in DONE gives o_done=0 and o_cpu_rst_n=0 on the next cycle with o_byte_ready=1.
  - i_start in LITTLE_END=1 mode: bytes 05 00 08 20 write word 20080005.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles bytes into 32-bit words, writes them to
// instruction memory from address 0, verifies a trailing XOR checksum, gates core reset.
module imem_loader #(
  parameter int ADDR_W     = 5,
  parameter bit LITTLE_END = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t          state;
  logic [ADDR_W:0] n_words;
  logic [ADDR_W:0] widx;
  logic [1:0]      bidx;
  logic [7:0]      acc;
  logic [31:0]     asm_q;
  logic [31:0]     asm_nxt;
  logic            xfer;

  assign xfer    = i_byte_valid && o_byte_ready;
  assign asm_nxt = LITTLE_END ? {i_byte, asm_q[31:8]} : {asm_q[23:0], i_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      n_words      <= '0;
      widx         <= '0;
      bidx         <= '0;
      acc          <= '0;
      asm_q        <= '0;
      o_byte_ready <= 1'b0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_cpu_rst_n  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            state        <= S_COUNT;
            o_byte_ready <= 1'b1;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_cpu_rst_n  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            // Count bits above the address width are dropped, so N is 1..2^ADDR_W.
            n_words <= {1'b0, i_byte[ADDR_W-1:0]} + ONE;
            widx    <= '0;
            bidx    <= '0;
            acc     <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_q <= asm_nxt;
            acc   <= acc ^ i_byte;
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              o_wdata <= asm_nxt;
              o_waddr <= widx[ADDR_W-1:0];
              o_we    <= 1'b1;
              widx    <= widx + ONE;
              // Extra index bit keeps a full 2^ADDR_W load from wrapping to 0.
              if (widx + ONE == n_words) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            o_byte_ready <= 1'b0;
            o_busy       <= 1'b0;
            if (i_byte == acc) begin
              state       <= S_DONE;
              o_done      <= 1'b1;
              o_cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              o_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: one big-endian and one little-endian instance
// share the stimulus; expected writes and outcome come from the raw byte stream.
module tb_imem_loader;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_d = '0;
  logic          valid = 1'b0;

  logic          rdy0, we0, cpu0, busy0, done0, err0;
  logic [AW-1:0] waddr0;
  logic [31:0]   wdata0;
  logic          rdy1, we1, cpu1, busy1, done1, err1;
  logic [AW-1:0] waddr1;
  logic [31:0]   wdata1;

  imem_loader #(.ADDR_W(AW), .LITTLE_END(1'b0)) d0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte(byte_d), .i_byte_valid(valid),
    .o_byte_ready(rdy0), .o_we(we0), .o_waddr(waddr0), .o_wdata(wdata0),
    .o_cpu_rst_n(cpu0), .o_busy(busy0), .o_done(done0), .o_err(err0));

  imem_loader #(.ADDR_W(AW), .LITTLE_END(1'b1)) d1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte(byte_d), .i_byte_valid(valid),
    .o_byte_ready(rdy1), .o_we(we1), .o_waddr(waddr1), .o_wdata(wdata1),
    .o_cpu_rst_n(cpu1), .o_busy(busy1), .o_done(done1), .o_err(err1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+31:0] cap0[$];
  logic [AW+31:0] cap1[$];
  logic [7:0]     dat[$];

  always @(posedge clk) begin
    #1;
    if (we0) cap0.push_back({waddr0, wdata0});
    if (we1) cap1.push_back({waddr1, wdata1});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, rdy0, 0);
    check({tag, "_we"}, we0, 0);
    check({tag, "_waddr"}, waddr0, 0);
    check({tag, "_wdata"}, wdata0, 0);
    check({tag, "_cpu_rst_n"}, cpu0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_err"}, err0, 0);
  endtask

  // Runs one load of count byte cnt plus the bytes in dat; abort_at limits transfers.
  task automatic load(input logic [7:0] cnt, input bit bad_chk, input bit rnd_valid,
                      input bit noise, input int abort_at);
    int n, cyc, sent, nwr;
    logic [7:0] x;
    logic [7:0] strm[$];
    logic [31:0] be, le;
    bit v, r;
    n = int'(cnt[AW-1:0]) + 1;
    x = '0;
    foreach (dat[i]) x ^= dat[i];
    strm = {cnt};
    foreach (dat[i]) strm.push_back(dat[i]);
    strm.push_back(bad_chk ? (x ^ 8'h01) : x);
    cap0.delete();
    cap1.delete();
    cyc = 0;
    sent = 0;

    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    check("start_ready", rdy0, 1);
    check("start_busy", busy0, 1);
    check("start_done", done0, 0);
    check("start_err", err0, 0);
    check("start_cpu_rst_n", cpu0, 0);
    @(negedge clk);
    while (strm.size() > 0 && sent < abort_at && cyc < 2000) begin
      v = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      r = rdy0;
      valid  = v;
      byte_d = v ? strm[0] : 8'($urandom);
      start  = noise && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      cyc++;
      if (v && r) begin
        void'(strm.pop_front());
        sent++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    start = 1'b0;

    if (sent >= abort_at) begin
      rst = 1'b1;
      #1;
      check_zero_outputs("midreset");
      check("midreset_writes", cap0.size(), (sent - 1) / 4);
      @(negedge clk) rst = 1'b0;
      return;
    end

    #1;
    check("stream_drained", strm.size(), 0);
    check("end_done", done0, !bad_chk);
    check("end_err", err0, bad_chk);
    check("end_cpu_rst_n", cpu0, !bad_chk);
    check("end_busy", busy0, 0);
    check("end_ready", rdy0, 0);
    check("le_done", done1, !bad_chk);
    check("le_cpu_rst_n", cpu1, !bad_chk);
    if (!rnd_valid) check("load_cycles", cyc, 4 * n + 2);
    check("write_count_be", cap0.size(), n);
    check("write_count_le", cap1.size(), n);
    nwr = (cap0.size() < n) ? cap0.size() : n;
    for (int i = 0; i < nwr; i++) begin
      be = {dat[4*i], dat[4*i+1], dat[4*i+2], dat[4*i+3]};
      check("write_be", cap0[i], {AW'(i), be});
    end
    nwr = (cap1.size() < n) ? cap1.size() : n;
    for (int i = 0; i < nwr; i++) begin
      le = {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]};
      check("write_le", cap1[i], {AW'(i), le});
    end
  endtask

  task automatic rand_data(input int words);
    dat.delete();
    for (int i = 0; i < 4 * words; i++) dat.push_back(8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    #1;
    check_zero_outputs("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle");

    dat = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    load(8'h01, 0, 0, 0, 1000);
    check("golden_word0", cap0.size() > 0 ? cap0[0] : '0, {5'd0, 32'h20080005});
    load(8'h01, 1, 0, 0, 1000);
    load(8'h01, 0, 1, 1, 1000);

    rand_data(32);
    load(8'h1F, 0, 0, 0, 1000);
    load(8'hFF, 0, 1, 0, 1000);

    dat = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    load(8'h01, 0, 0, 0, 7);
    load(8'h01, 0, 0, 0, 1000);

    dat = {8'h05, 8'h00, 8'h08, 8'h20};
    load(8'h00, 0, 0, 0, 1000);
    check("le_golden", cap1.size() > 0 ? cap1[0] : '0, {5'd0, 32'h20080005});

    for (int k = 0; k < 10; k++) begin
      c = 8'($urandom);
      rand_data(int'(c[AW-1:0]) + 1);
      load(c, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
